// File: rtl/avalon_st_packet_enforcer.sv
// Avalon-ST packet enforcer: repairs untrusted packet framing, caps packet
// length, and flags/counts protocol violations behind a registered output.
module avalon_st_packet_enforcer #(
   parameter int DATA_WIDTH    = 64,
   parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH/8),
   parameter int MAX_PKT_WORDS = 256,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DATA_WIDTH-1:0]  in_data,
   input  logic                   in_valid,
   input  logic                   in_sop,
   input  logic                   in_eop,
   input  logic [EMPTY_WIDTH-1:0] in_empty,
   output logic                   in_rdy,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic                   out_valid,
   output logic                   out_sop,
   output logic                   out_eop,
   output logic [EMPTY_WIDTH-1:0] out_empty,
   output logic                   out_error,
   input  logic                   out_rdy,
   input  logic                   clear_counters,
   output logic                   valid_out_of_packet,
   output logic                   wrong_sop,
   output logic                   len_violation,
   output logic [CNT_WIDTH-1:0]   cnt_oop,
   output logic [CNT_WIDTH-1:0]   cnt_sop_err,
   output logic [CNT_WIDTH-1:0]   cnt_len_err
);

   localparam int WC_W = $clog2(MAX_PKT_WORDS + 1);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PKT  = 2'd1;
   localparam logic [1:0] S_DROP = 2'd2;
   localparam logic [WC_W-1:0] LAST_WC = WC_W'(MAX_PKT_WORDS - 1);

   logic [1:0]             state_q, state_d;
   logic [WC_W-1:0]        wc_q, wc_d;
   logic [DATA_WIDTH-1:0]  data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   sop_q, sop_d;
   logic                   eop_q, eop_d;
   logic [EMPTY_WIDTH-1:0] empty_q, empty_d;
   logic                   err_q, err_d;
   logic                   oop_q, sop_err_q, len_q;
   logic [CNT_WIDTH-1:0]   c_oop_q, c_sop_q, c_len_q;

   logic                   free, inject, accept, fwd;
   logic                   f_eop, f_err;
   logic [EMPTY_WIDTH-1:0] f_empty;
   logic                   oop_ev, sop_ev, len_ev;

   always_comb begin
      free   = ~valid_q | out_rdy;
      inject = (state_q == S_PKT) & in_valid & in_sop & free;
      // A sop in DROP is forwarded, so it must wait for a free register.
      if (state_q == S_DROP) in_rdy = ~(in_valid & in_sop) | free;
      else                   in_rdy = free & ~inject;
      accept  = in_valid & in_rdy;
      state_d = state_q;
      wc_d    = wc_q;
      fwd     = 1'b0;
      f_eop   = in_eop;
      f_err   = 1'b0;
      f_empty = in_eop ? in_empty : '0;
      oop_ev  = 1'b0;
      sop_ev  = 1'b0;
      len_ev  = 1'b0;
      case (state_q)
         S_IDLE: if (accept) begin
            if (in_sop) begin
               fwd = 1'b1;
               if (!in_eop) begin
                  state_d = S_PKT;
                  wc_d    = WC_W'(1);
               end
            end else begin
               oop_ev = 1'b1;
            end
         end
         S_PKT: if (inject) begin
            sop_ev  = 1'b1;
            state_d = S_IDLE;
         end else if (accept) begin
            fwd = 1'b1;
            if (in_eop) begin
               state_d = S_IDLE;
            end else if (wc_q == LAST_WC) begin
               f_eop   = 1'b1;
               f_err   = 1'b1;
               f_empty = '0;
               len_ev  = 1'b1;
               state_d = S_DROP;
            end else begin
               wc_d = wc_q + 1'b1;
            end
         end
         S_DROP: if (accept) begin
            if (in_sop) begin
               sop_ev = 1'b1;
               fwd    = 1'b1;
               if (!in_eop) begin
                  state_d = S_PKT;
                  wc_d    = WC_W'(1);
               end else begin
                  state_d = S_IDLE;
               end
            end else if (in_eop) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      sop_d   = sop_q;
      eop_d   = eop_q;
      empty_d = empty_q;
      err_d   = err_q;
      if (free) begin
         valid_d = inject | fwd;
         data_d  = fwd ? in_data : '0;
         sop_d   = fwd & in_sop;
         eop_d   = inject | (fwd & f_eop);
         empty_d = fwd ? f_empty : '0;
         err_d   = inject | (fwd & f_err);
      end
   end

   function automatic logic [CNT_WIDTH-1:0] bump(
      input logic [CNT_WIDTH-1:0] c, input logic ev, input logic clr);
      if (clr)            return '0;
      else if (ev && ~&c) return c + 1'b1;
      else                return c;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         wc_q      <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         sop_q     <= 1'b0;
         eop_q     <= 1'b0;
         empty_q   <= '0;
         err_q     <= 1'b0;
         oop_q     <= 1'b0;
         sop_err_q <= 1'b0;
         len_q     <= 1'b0;
         c_oop_q   <= '0;
         c_sop_q   <= '0;
         c_len_q   <= '0;
      end else begin
         state_q   <= state_d;
         wc_q      <= wc_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         sop_q     <= sop_d;
         eop_q     <= eop_d;
         empty_q   <= empty_d;
         err_q     <= err_d;
         oop_q     <= oop_ev;
         sop_err_q <= sop_ev;
         len_q     <= len_ev;
         c_oop_q   <= bump(c_oop_q, oop_ev, clear_counters);
         c_sop_q   <= bump(c_sop_q, sop_ev, clear_counters);
         c_len_q   <= bump(c_len_q, len_ev, clear_counters);
      end
   end

   assign out_data            = data_q;
   assign out_valid           = valid_q;
   assign out_sop             = sop_q;
   assign out_eop             = eop_q;
   assign out_empty           = empty_q;
   assign out_error           = err_q;
   assign valid_out_of_packet = oop_q;
   assign wrong_sop           = sop_err_q;
   assign len_violation       = len_q;
   assign cnt_oop             = c_oop_q;
   assign cnt_sop_err         = c_sop_q;
   assign cnt_len_err         = c_len_q;

endmodule

// File: tb/tb_avalon_st_packet_enforcer.sv
// Scoreboard bench for avalon_st_packet_enforcer with MAX_PKT_WORDS=4.
// Directed stimulus pushes expected beats; a negedge monitor pops them.
module tb_avalon_st_packet_enforcer;

   typedef struct packed {
      logic [63:0] d;
      logic        sop;
      logic        eop;
      logic [2:0]  empty;
      logic        err;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [63:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_sop = 1'b0;
   logic        in_eop = 1'b0;
   logic [2:0]  in_empty = '0;
   logic        in_rdy;
   logic [63:0] out_data;
   logic        out_valid, out_sop, out_eop, out_error;
   logic [2:0]  out_empty;
   logic        out_rdy = 1'b1;
   logic        clear_counters = 1'b0;
   logic        valid_out_of_packet, wrong_sop, len_violation;
   logic [15:0] cnt_oop, cnt_sop_err, cnt_len_err;

   int compared = 0;
   int mismatched = 0;
   int n_oop = 0, n_sop = 0, n_len = 0;
   beat_t exp_q[$];

   always #5 clk = ~clk;

   avalon_st_packet_enforcer #(
      .DATA_WIDTH(64),
      .EMPTY_WIDTH(3),
      .MAX_PKT_WORDS(4),
      .CNT_WIDTH(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_sop(in_sop),
      .in_eop(in_eop),
      .in_empty(in_empty),
      .in_rdy(in_rdy),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_sop(out_sop),
      .out_eop(out_eop),
      .out_empty(out_empty),
      .out_error(out_error),
      .out_rdy(out_rdy),
      .clear_counters(clear_counters),
      .valid_out_of_packet(valid_out_of_packet),
      .wrong_sop(wrong_sop),
      .len_violation(len_violation),
      .cnt_oop(cnt_oop),
      .cnt_sop_err(cnt_sop_err),
      .cnt_len_err(cnt_len_err)
   );

   task automatic chk(input string nm, input logic [79:0] act,
                      input logic [79:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic expect_beat(input logic [63:0] d, input logic s,
                              input logic e, input logic [2:0] em,
                              input logic er);
      beat_t b;
      b = '{d: d, sop: s, eop: e, empty: em, err: er};
      exp_q.push_back(b);
   endtask

   task automatic send(input logic [63:0] d, input logic s,
                       input logic e, input logic [2:0] em);
      logic ok;
      in_valid = 1'b1;
      in_data  = d;
      in_sop   = s;
      in_eop   = e;
      in_empty = em;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         ok = in_rdy;
         @(posedge clk);
         #1;
         if (ok) return;
      end
      compared++;
      mismatched++;
      $display("FAIL send_timeout: data %h never accepted", d);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_eop   = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_cnt(input string nm, input int o, input int s,
                          input int l);
      chk({nm, "_cnt_oop"}, 80'(cnt_oop), 80'(o));
      chk({nm, "_cnt_sop"}, 80'(cnt_sop_err), 80'(s));
      chk({nm, "_cnt_len"}, 80'(cnt_len_err), 80'(l));
   endtask

   task automatic chk_pulses(input string nm, input int o, input int s,
                             input int l);
      chk({nm, "_pulse_oop"}, 80'(n_oop), 80'(o));
      chk({nm, "_pulse_sop"}, 80'(n_sop), 80'(s));
      chk({nm, "_pulse_len"}, 80'(n_len), 80'(l));
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (valid_out_of_packet) n_oop++;
         if (wrong_sop)           n_sop++;
         if (len_violation)       n_len++;
         if (out_valid && out_rdy) begin
            if (exp_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_beat: got data %h, none expected",
                        out_data);
            end else begin
               beat_t e;
               beat_t a;
               e = exp_q.pop_front();
               a = '{d: out_data, sop: out_sop, eop: out_eop,
                     empty: out_empty, err: out_error};
               chk("beat", 80'(a), 80'(e));
            end
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", 80'(out_valid), 80'(0));
      chk("rst_in_rdy", 80'(in_rdy), 80'(1));
      chk_cnt("rst", 0, 0, 0);
      @(posedge clk);
      #1;

      // clean 3-beat packet; non-eop empty must be zeroed
      expect_beat(64'hA1, 1, 0, 0, 0);
      expect_beat(64'hA2, 0, 0, 0, 0);
      expect_beat(64'hA3, 0, 1, 3, 0);
      send(64'hA1, 1, 0, 5);
      send(64'hA2, 0, 0, 2);
      send(64'hA3, 0, 1, 3);
      idle(3);
      chk_cnt("clean", 0, 0, 0);
      chk_pulses("clean", 0, 0, 0);

      // beat outside a packet
      send(64'hBAD, 0, 0, 0);
      idle(3);
      chk_cnt("oop", 1, 0, 0);
      chk_pulses("oop", 1, 0, 0);

      // sop inside open packet -> synthetic closing beat
      expect_beat(64'hD1, 1, 0, 0, 0);
      expect_beat(64'hD2, 0, 0, 0, 0);
      expect_beat(64'h0,  0, 1, 0, 1);
      expect_beat(64'hE1, 1, 0, 0, 0);
      expect_beat(64'hE2, 0, 1, 6, 0);
      send(64'hD1, 1, 0, 0);
      send(64'hD2, 0, 0, 0);
      send(64'hE1, 1, 0, 0);
      send(64'hE2, 0, 1, 6);
      idle(3);
      chk_cnt("sop", 1, 1, 0);
      chk_pulses("sop", 1, 1, 0);

      // 6-beat packet truncated at 4
      expect_beat(64'hF1, 1, 0, 0, 0);
      expect_beat(64'hF2, 0, 0, 0, 0);
      expect_beat(64'hF3, 0, 0, 0, 0);
      expect_beat(64'hF4, 0, 1, 0, 1);
      send(64'hF1, 1, 0, 0);
      send(64'hF2, 0, 0, 0);
      send(64'hF3, 0, 0, 0);
      send(64'hF4, 0, 0, 4);
      send(64'hF5, 0, 0, 0);
      send(64'hF6, 0, 1, 2);
      idle(3);
      chk_cnt("len", 1, 1, 1);
      chk_pulses("len", 1, 1, 1);

      clear_counters = 1'b1;
      @(posedge clk);
      #1 clear_counters = 1'b0;
      chk_cnt("clear", 0, 0, 0);

      // downstream stall mid-packet
      expect_beat(64'hC1, 1, 0, 0, 0);
      expect_beat(64'hC2, 0, 0, 0, 0);
      expect_beat(64'hC3, 0, 0, 0, 0);
      expect_beat(64'hC4, 0, 1, 1, 0);
      fork
         begin
            send(64'hC1, 1, 0, 0);
            send(64'hC2, 0, 0, 0);
            send(64'hC3, 0, 0, 0);
            send(64'hC4, 0, 1, 1);
         end
         begin
            repeat (2) @(posedge clk);
            #1 out_rdy = 1'b0;
            repeat (5) begin
               @(negedge clk);
               chk("stall_hold", 80'(out_data), 80'(64'hC2));
               chk("stall_in_rdy", 80'(in_rdy), 80'(0));
            end
            @(posedge clk);
            #1 out_rdy = 1'b1;
         end
      join
      idle(3);
      chk_cnt("stall", 0, 0, 0);

      // reset while a packet is open
      expect_beat(64'h71, 1, 0, 0, 0);
      send(64'h71, 1, 0, 0);
      send(64'h72, 0, 0, 0);
      in_valid = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rst2_out_valid", 80'(out_valid), 80'(0));
      @(posedge clk);
      #1;
      expect_beat(64'h81, 1, 0, 0, 0);
      expect_beat(64'h82, 0, 1, 7, 0);
      send(64'h81, 1, 0, 0);
      send(64'h82, 0, 1, 7);
      idle(4);
      chk_cnt("rst2", 0, 0, 0);
      chk_pulses("rst2", 1, 1, 1);
      chk("drain", 80'(exp_q.size()), 80'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
